// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes,
// sequencer states, ALU operation classes and datapath select encodings.
package riscv_ctrl_pkg;

  // Opcodes handled by the sequencer
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Sequencer states
  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL
  } state_e;

  // ALU operation class requested by the sequencer
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format implied by the opcode; the generator runs every cycle
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] sel;
    case (op)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Maps the sequencer's ALU operation class plus instruction fields onto
// the shared ALU's operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_e     alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // Only register-register funct3 000 with funct7b5 set is a subtract
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multi-cycle RV32I core: steps each instruction
// through fetch/decode/execute/memory/writeback, drives the datapath selects
// and enables, and abandons an instruction whose memory access never completes.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       bus_error
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             timeout;
  aluop_e           alu_op;
  logic [2:0]       alu_dec;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_dec)
  );

  // A timeout fires on the last permitted wait cycle unless memory answers in it
  always_comb begin
    waiting = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    timeout = (MEM_TIMEOUT != 0) && waiting && !mem_ready && (wait_cnt == CNT_LAST);
  end

  // State register, forced back to FETCH by reset even mid-access
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Wait counter restarts on every state change, completion or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state_next != state) || mem_ready || timeout) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Per-state output decode and next-state selection, then timeout and reset overrides
  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RD2;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;
    alu_op        = ALUOP_ADD;

    case (state)
      FETCH: begin
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECUTER;
          OP_ITYPE:          state_next = EXECUTEI;
          OP_BRANCH:         state_next = BEQ;
          OP_JAL:            state_next = JAL;
          default: begin
            illegal_instr = 1'b1;
            state_next    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (mem_ready) begin
          state_next = MEMWB;
        end
      end
      MEMWB: begin
        result_src = RES_READDATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = FETCH;
        end
      end
      EXECUTER: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end
      default: begin
        state_next = FETCH;
      end
    endcase

    imm_src     = imm_src_of(op);
    alu_control = alu_dec;

    if (timeout) begin
      bus_error  = 1'b1;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      state_next = FETCH;
    end

    if (rst) begin
      state_next    = FETCH;
      pc_write      = 1'b0;
      adr_src       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      imm_src       = 2'b00;
      reg_write     = 1'b0;
      alu_control   = 3'b000;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
      bus_error     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for the multi-cycle control sequencer: each instruction's
// expected signature is pushed when it is issued, and a monitor pops and
// compares it on every retire / illegal / bus-error pulse.
module tb_multicycle_control_fsm;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       instr_done, illegal_instr, bus_error;

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_src       (imm_src),
    .reg_write     (reg_write),
    .alu_control   (alu_control),
    .instr_done    (instr_done),
    .illegal_instr (illegal_instr),
    .bus_error     (bus_error)
  );

  always #5 clk = ~clk;

  // kind: 0 retire, 1 illegal, 2 bus error; ex = {seen, alu_src_b, alu_control} while operand A is RD1
  typedef struct {
    int         kind;
    int         cycles;
    int         n_ir;
    int         n_pc;
    int         n_reg;
    int         n_mw;
    logic [5:0] ex;
    logic [1:0] ev_res;
    logic       ev_adr;
    logic [1:0] ev_imm;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         vec_count = 0;
  int         miss_count = 0;
  int         st_cycles = 0, st_ir = 0, st_pc = 0, st_reg = 0, st_mw = 0;
  logic [5:0] st_ex = 6'd0;
  int         mon_kind;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_count++;
    if (actual != expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic mr, input logic [31:0] instr, input logic z);
    mem_ready = mr;
    op        = instr[6:0];
    funct3    = instr[14:12];
    funct7b5  = instr[30];
    zero      = z;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference model: expand one instruction into its mem_ready plan and expected signature
  task automatic run_instr(input logic [31:0] instr, input int wf, input int wm, input logic z);
    exp_t       e;
    bit         plan[$];
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    o  = instr[6:0];
    f3 = instr[14:12];
    f7 = instr[30];
    e.kind = 0; e.n_ir = 0; e.n_pc = 0; e.n_reg = 0; e.n_mw = 0;
    e.ex = 6'd0; e.ev_res = 2'b00; e.ev_adr = 1'b0;
    e.ev_imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
               (o == 7'b1101111) ? 2'b11 : 2'b00;
    if (wf >= TMO) begin
      repeat (TMO) plan.push_back(1'b0);
      e.kind   = 2;
      e.ev_res = 2'b10;
    end else begin
      repeat (wf) plan.push_back(1'b0);
      plan.push_back(1'b1);
      e.n_ir = 1;
      e.n_pc = 1;
      plan.push_back(rbit());
      case (o)
        7'b0110011, 7'b0010011: begin
          plan.push_back(rbit());
          plan.push_back(rbit());
          e.n_reg = 1;
          e.ex = {1'b1, (o == 7'b0110011) ? 2'b00 : 2'b01, alu_ref(o, f3, f7)};
        end
        7'b0000011, 7'b0100011: begin
          plan.push_back(rbit());
          e.ex = {1'b1, 2'b01, 3'b000};
          if (wm >= TMO) begin
            repeat (TMO) plan.push_back(1'b0);
            e.kind   = 2;
            e.ev_adr = 1'b1;
            if (o[5]) e.n_mw = TMO;
          end else begin
            repeat (wm) plan.push_back(1'b0);
            plan.push_back(1'b1);
            if (o[5]) begin
              e.n_mw   = wm + 1;
              e.ev_adr = 1'b1;
            end else begin
              plan.push_back(rbit());
              e.n_reg  = 1;
              e.ev_res = 2'b01;
            end
          end
        end
        7'b1100011: begin
          plan.push_back(rbit());
          e.ex   = {1'b1, 2'b00, 3'b001};
          e.n_pc = e.n_pc + int'(z);
        end
        7'b1101111: begin
          plan.push_back(rbit());
          plan.push_back(rbit());
          e.n_pc  = e.n_pc + 1;
          e.n_reg = 1;
        end
        default: e.kind = 1;
      endcase
    end
    e.cycles = plan.size();
    sb_q.push_back(e);
    foreach (plan[i]) applyStimulus(plan[i], instr, z);
  endtask

  // Monitor: accumulate per-instruction activity and compare on each terminating pulse
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("reset_outputs_zero",
                  int'({pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                        alu_src_b, imm_src, reg_write, alu_control, instr_done,
                        illegal_instr, bus_error}), 0);
      st_cycles = 0; st_ir = 0; st_pc = 0; st_reg = 0; st_mw = 0; st_ex = 6'd0;
    end else begin
      st_cycles = st_cycles + 1;
      st_ir  = st_ir  + int'(ir_write);
      st_pc  = st_pc  + int'(pc_write);
      st_reg = st_reg + int'(reg_write);
      st_mw  = st_mw  + int'(mem_write);
      if (alu_src_a == 2'b10) st_ex = {1'b1, alu_src_b, alu_control};
      if (instr_done || illegal_instr || bus_error) begin
        mon_kind = bus_error ? 2 : (illegal_instr ? 1 : 0);
        if (sb_q.size() == 0) begin
          vec_count++;
          miss_count++;
          $display("[TB] FAIL unexpected_event: got kind %0d, expected no event (t=%0t)", mon_kind, $time);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("single_pulse", int'(instr_done) + int'(illegal_instr) + int'(bus_error), 1);
          checkOutput("event_kind", mon_kind, mon_e.kind);
          checkOutput("cycle_count", st_cycles, mon_e.cycles);
          checkOutput("ir_write_count", st_ir, mon_e.n_ir);
          checkOutput("pc_write_count", st_pc, mon_e.n_pc);
          checkOutput("reg_write_count", st_reg, mon_e.n_reg);
          checkOutput("mem_write_count", st_mw, mon_e.n_mw);
          checkOutput("exec_srcb_alu", int'(st_ex), int'(mon_e.ex));
          checkOutput("result_src_end", int'(result_src), int'(mon_e.ev_res));
          checkOutput("adr_src_end", int'(adr_src), int'(mon_e.ev_adr));
          checkOutput("imm_src_end", int'(imm_src), int'(mon_e.ev_imm));
        end
        st_cycles = 0; st_ir = 0; st_pc = 0; st_reg = 0; st_mw = 0; st_ex = 6'd0;
      end
    end
  end

  // Directed program, a reset dropped mid-store, then randomized instruction mix
  initial begin
    logic [31:0] instr;
    int          pick;
    int          wf;
    int          wm;
    rst = 1'b1;
    mem_ready = 1'b1;
    op = 7'b0100011;
    zero = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(32'h002081B3, 0, 0, 1'b0);
    run_instr(32'h402081B3, 0, 0, 1'b0);
    run_instr(32'h00A08093, 0, 0, 1'b1);
    run_instr(32'h0020A423, 0, 3, 1'b0);
    run_instr(32'h00208463, 0, 0, 1'b1);
    run_instr(32'h00208463, 1, 0, 1'b0);
    run_instr(32'h0000A103, 0, TMO, 1'b0);
    run_instr(32'h0000A103, 2, TMO - 1, 1'b0);
    run_instr(32'h0000007F, 0, 0, 1'b0);
    run_instr(32'h002081B3, TMO, 0, 1'b0);
    run_instr(32'h008000EF, 0, 0, 1'b0);
    run_instr(32'h0020A423, 0, TMO, 1'b0);

    applyStimulus(1'b1, 32'h0020A423, 1'b0);
    applyStimulus(1'b1, 32'h0020A423, 1'b0);
    applyStimulus(1'b0, 32'h0020A423, 1'b0);
    applyStimulus(1'b0, 32'h0020A423, 1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("mem_write_before_reset", int'(mem_write), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(32'h002081B3, 0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      instr = $urandom;
      pick = $urandom_range(0, 7);
      case (pick)
        0: instr[6:0] = 7'b0110011;
        1: instr[6:0] = 7'b0010011;
        2: instr[6:0] = 7'b0000011;
        3: instr[6:0] = 7'b0100011;
        4: instr[6:0] = 7'b1100011;
        5: instr[6:0] = 7'b1101111;
        6: instr[6:0] = 7'b0110111;
        default: ;
      endcase
      wf = ($urandom_range(0, 11) == 0) ? TMO : $urandom_range(0, 3);
      pick = $urandom_range(0, 9);
      wm = (pick == 0) ? TMO : ((pick == 1) ? TMO - 1 : $urandom_range(0, 4));
      run_instr(instr, wf, wm, rbit());
    end

    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
